// File: rtl/frame_rate_meter.sv
// ============================================================================
//  Module   : frame_rate_meter
//  Purpose  : Counts frame-complete rising edges over a fixed gate window and
//             publishes a saturating 8-bit frames-per-window figure.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_rate_meter #(
    parameter int unsigned GATE_CYCLES = 50000000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       enable_i,
    input  logic       frame_done_i,
    input  logic       freeze_i,
    output logic [7:0] count_o,
    output logic       overflow_o,
    output logic       update_o
);

    localparam int unsigned c_gate_w = $clog2(GATE_CYCLES);
    localparam logic [c_gate_w-1:0] c_gate_last = c_gate_w'(GATE_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [c_gate_w-1:0] gate_q, gate_d;
    logic [7:0]          acc_q, acc_d;
    logic                sat_q, sat_d;
    logic                fd_q;
    logic [7:0]          count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                upd_q, upd_d;

    logic                w_ev;
    logic                w_acc_full;
    logic [7:0]          w_pub;
    logic                w_pub_ovf;

    assign w_ev       = frame_done_i & ~fd_q;
    assign w_acc_full = (acc_q == 8'hFF);
    // Closing value folds in an edge arriving on the last gate cycle.
    assign w_pub      = w_acc_full ? 8'hFF : (acc_q + {7'd0, w_ev});
    assign w_pub_ovf  = sat_q | (w_acc_full & w_ev);

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        upd_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                gate_d = '0;
                acc_d  = '0;
                sat_d  = 1'b0;
                if (enable_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!enable_i) begin
                    // Partial window is thrown away.
                    state_d = S_IDLE;
                    gate_d  = '0;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                end else if (gate_q == c_gate_last) begin
                    if (!freeze_i) begin
                        count_d = w_pub;
                        ovf_d   = w_pub_ovf;
                        upd_d   = 1'b1;
                    end
                    gate_d = '0;
                    acc_d  = '0;
                    sat_d  = 1'b0;
                end else begin
                    gate_d = gate_q + 1'b1;
                    if (w_ev) begin
                        if (w_acc_full) begin
                            sat_d = 1'b1;
                        end else begin
                            acc_d = acc_q + 8'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Edge register resets high so a level already present at release is ignored.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            gate_q  <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            fd_q    <= 1'b1;
            count_q <= '0;
            ovf_q   <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            fd_q    <= frame_done_i;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            upd_q   <= upd_d;
        end
    end

    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign update_o   = upd_q;

endmodule

`default_nettype wire

// File: doc/frame_rate_meter.md
Name: frame_rate_meter

Overview:
Measures the LED frame refresh rate. It counts completed frames over a fixed gate window and presents the result as an 8-bit value. It sits directly upstream of the two-digit segment LED driver and feeds that driver's count input. The driver shows 0..99 on the digits and flags hundreds on the decimal points, so the 0..255 output range is fully usable.

Parameters:
GATE_CYCLES, 50000000, clk_i cycles per measurement window (1 s at 50 MHz); must be >= 2; benches override it to small values.

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous reset, active-low
enable_i  input  1  measurement enable, level, synchronous to clk_i
frame_done_i  input  1  frame-complete indication, level or pulse, synchronous to clk_i; one frame is counted per rising edge
freeze_i  input  1  when high, count_o/overflow_o hold their values; measurement continues internally
count_o  output  8  frames counted in the last completed window, saturating at 255
overflow_o  output  1  high if the last published window saturated (true count > 255)
update_o  output  1  one-cycle strobe, high in the cycle after count_o is (re)published

Behaviour:
- Reset (asynchronous assert, synchronous deassert by clock usage): count_o=0, overflow_o=0, update_o=0, gate counter=0, accumulator=0, sat flag=0, state=IDLE, edge register=1.
- Edge register reset value: because the edge register resets to 1, a frame_done_i already high at reset release is not counted.
- Edge detect: ev = frame_done_i & ~frame_done_q. frame_done_q is registered every cycle regardless of state.
- FSM, two states:
  - IDLE: gate counter and accumulator held at 0. count_o/overflow_o hold their values. update_o=0. IDLE->RUN when enable_i=1.
  - RUN: gate counter increments each cycle 0..GATE_CYCLES-1. RUN->IDLE when enable_i=0, checked with priority over everything else. A partial window is discarded: no publish, no update_o, accumulator cleared.
- Window start: the first RUN cycle is gate count 0. An ev in that cycle counts.
- Accumulation in RUN: acc <= acc+1 on ev. If acc==255 and ev occurs, acc stays 255 and sat is set.
- Window close (gate==GATE_CYCLES-1, enable_i=1):
  - The closing value includes any ev in this cycle.
  - Published value = min(acc+ev, 255). ovf = sat | (acc==255 & ev).
  - If freeze_i=0: count_o <= published value, overflow_o <= ovf, update_o <= 1 on that same edge.
  - If freeze_i=1: outputs unchanged and update_o stays 0; the window result is discarded.
  - Regardless of freeze_i: gate counter <= 0, acc <= 0, sat <= 0. The next window starts with no gap cycle.
- Output timing: update_o is high for exactly one cycle and coincides with the new count_o. Publish interval is exactly GATE_CYCLES cycles in steady RUN.
- Width rules:
  - Gate counter width = clog2(GATE_CYCLES).
  - Accumulator is 8 bits plus a sticky sat bit; no wrap-around is ever visible.
- freeze_i only masks publication. It never stalls gating. Releasing freeze_i has no immediate effect; the next window close publishes.
- Reset mid-window: all state returns to reset values immediately. count_o goes to 0, so the downstream display shows 00 while reset is held.

Test Plan:
(GATE_CYCLES=100 for all.)
- Basic count: enable_i=1 from reset release; 37 single-cycle pulses in window 1 -> at cycle 100, count_o=37, overflow_o=0, update_o high for 1 cycle. Next publish at cycle 200.
- Level input and edge at reset: frame_done_i held high through reset release, then 5 high/low toggles -> count_o=5. The initial high level is not counted and a held level counts once.
- Boundary events: pulses at gate counts 0 and 99 plus 10 pulses in between -> count_o=12. A pulse at count 0 of window 2 appears only in window 2's result.
- Saturation: frame_done_i toggles every cycle (50 rising edges/window) with GATE_CYCLES=600 override (300 edges) -> count_o=255, overflow_o=1. Following window with 3 edges -> count_o=3, overflow_o=0.
- Freeze: window 1 = 20 edges, published. Window 2 = 40 edges with freeze_i=1 at its close -> count_o stays 20, no update_o. Window 3 = 7 edges with freeze_i=0 -> count_o=7 with update_o.
- Enable drop and reset: enable_i=0 at gate count 50 -> no publish, count_o unchanged. Re-enable -> next publish exactly 100 cycles after re-enable. rst_n_i pulse mid-window -> count_o=0 and update_o=0 immediately (asynchronous).
